// File: rtl/pipe_collision_scorer.sv
// Game-level scorer: detects bird/pipe and bird/floor collisions, counts cleared pipes,
// keeps a high score and runs the IDLE/PLAY/LOST state machine.
module pipe_collision_scorer #(
    parameter int BIRD_X      = 100,
    parameter int BIRD_SIZE   = 20,
    parameter int PIPE_W      = 60,
    parameter int GAP_H       = 150,
    parameter int FLOOR_Y     = 480,
    parameter int HIT_CONFIRM = 2,
    parameter int SCORE_MAX   = 999
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [9:0] BirdPosY,
    input  logic [9:0] PipePosXA,
    input  logic [9:0] PipePosYA,
    output logic       Lost,
    output logic       Playing,
    output logic       Passed,
    output logic [9:0] Score,
    output logic [9:0] HighScore
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_LOST = 2'd2
    } state_t;

    localparam logic [10:0] BIRD_L   = 11'(BIRD_X);
    localparam logic [10:0] BIRD_R   = 11'(BIRD_X + BIRD_SIZE);
    localparam logic [10:0] BIRD_SZ  = 11'(BIRD_SIZE);
    localparam logic [10:0] PIPE_WD  = 11'(PIPE_W);
    localparam logic [10:0] GAP_HT   = 11'(GAP_H);
    localparam logic [10:0] FLOOR_L  = 11'(FLOOR_Y);
    localparam logic [9:0]  SCORE_MX = 10'(SCORE_MAX);
    localparam logic [3:0]  CONFIRM  = 4'(HIT_CONFIRM);

    state_t      state_q, state_d;
    logic [9:0]  score_q, score_d;
    logic [9:0]  high_q, high_d;
    logic [2:0]  hit_cnt_q, hit_cnt_d;
    logic        armed_q, armed_d;
    logic        passed_q, passed_d;
    logic        lost_q, lost_d;
    logic        playing_q, playing_d;

    // 11-bit extended geometry so the sums never wrap
    logic [10:0] pipe_l, pipe_r, gap_top, gap_bot, bird_top, bird_bot;
    logic        xov, outgap, on_floor, hit, score_cond, rearm, confirm;

    assign pipe_l   = {1'b0, PipePosXA};
    assign pipe_r   = pipe_l + PIPE_WD;
    assign gap_top  = {1'b0, PipePosYA};
    assign gap_bot  = gap_top + GAP_HT;
    assign bird_top = {1'b0, BirdPosY};
    assign bird_bot = bird_top + BIRD_SZ;

    assign xov        = (pipe_l < BIRD_R) && (pipe_r > BIRD_L);
    assign outgap     = (bird_top < gap_top) || (bird_bot > gap_bot);
    assign on_floor   = (bird_bot >= FLOOR_L);
    assign hit        = (xov && outgap) || on_floor;
    assign score_cond = (pipe_r < BIRD_L);
    assign rearm      = (pipe_l >= BIRD_R);
    assign confirm    = hit && (({1'b0, hit_cnt_q} + 4'd1) >= CONFIRM);

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        high_d    = high_q;
        hit_cnt_d = hit_cnt_q;
        armed_d   = armed_q;
        passed_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                score_d   = '0;
                hit_cnt_d = '0;
                armed_d   = 1'b1;
                if (Start) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (!Start) begin
                    state_d   = S_IDLE;
                    score_d   = '0;
                    hit_cnt_d = '0;
                    armed_d   = 1'b1;
                end else begin
                    hit_cnt_d = hit ? hit_cnt_q + 3'd1 : 3'd0;
                    // A confirming hit pre-empts scoring in the same cycle
                    if (confirm) begin
                        state_d = S_LOST;
                        high_d  = (score_q > high_q) ? score_q : high_q;
                    end else if (armed_q && score_cond) begin
                        armed_d  = 1'b0;
                        passed_d = 1'b1;
                        if (score_q < SCORE_MX) score_d = score_q + 10'd1;
                    end else if (rearm) begin
                        armed_d = 1'b1;
                    end
                end
            end
            S_LOST: begin
                if (!Start) begin
                    state_d   = S_IDLE;
                    score_d   = '0;
                    hit_cnt_d = '0;
                    armed_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        lost_d    = (state_d == S_LOST);
        playing_d = (state_d == S_PLAY);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            high_q    <= '0;
            hit_cnt_q <= '0;
            armed_q   <= 1'b1;
            passed_q  <= 1'b0;
            lost_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            high_q    <= high_d;
            hit_cnt_q <= hit_cnt_d;
            armed_q   <= armed_d;
            passed_q  <= passed_d;
            lost_q    <= lost_d;
            playing_q <= playing_d;
        end
    end

    assign Lost      = lost_q;
    assign Playing   = playing_q;
    assign Passed    = passed_q;
    assign Score     = score_q;
    assign HighScore = high_q;

endmodule
